// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: access-size codes, controller
// states, and helpers for byte strobes and alignment.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Strobe for up to 8 byte lanes; callers keep only the lanes they have.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  // A dword is only legal on a 64-bit memory.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] low,
                                      input logic wide);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return low[0];
      SZ_W:    return |low[1:0];
      default: return !wide || (|low);
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: shifts the addressed bytes down to bit 0 and sign- or
// zero-extends the selected field to the full data width.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int N = 32,
  localparam int LB = $clog2(N / 8)
) (
  input  logic [N-1:0]  word,
  input  logic [1:0]    size,
  input  logic [LB-1:0] lane,
  input  logic          uns,
  output logic [N-1:0]  data
);

  logic [N-1:0] shifted;
  logic [N-1:0] fmask;
  logic         sbit;

  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    fmask = '1;
    sbit  = 1'b0;
    case (size)
      SZ_B: begin
        fmask = N'(8'hFF);
        sbit  = shifted[7];
      end
      SZ_H: begin
        fmask = N'(16'hFFFF);
        sbit  = shifted[15];
      end
      SZ_W: begin
        fmask = N'(32'hFFFF_FFFF);
        sbit  = shifted[31];
      end
      default: begin
        fmask = '1;
        sbit  = shifted[N-1];
      end
    endcase
    data = (shifted & fmask) | ((!uns && sbit) ? ~fmask : '0);
  end

endmodule

// File: rtl/dmem_sized.sv
// Single-port sized data memory: byte-strobed stores, one-cycle registered
// extended loads, misalignment rejection and a post-reset array clear sweep.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 10,
  parameter bit CLEAR_ON_RST = 1'b1,
  localparam int LB = $clog2(N / 8),
  localparam int AB = M + LB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          WE,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [AB-1:0] adrs,
  input  logic [N-1:0]  data_w,
  output logic [N-1:0]  data_r,
  output logic          rvalid,
  output logic          misalign,
  output logic          busy
);

  // Handshake: req is a single-cycle request with no backpressure; it is
  // accepted at the edge only while busy=0, and a load answers with exactly
  // one rvalid pulse in the following cycle (misalign rides along if rejected).

  state_t         state, state_nx;
  logic [M-1:0]   cnt;
  logic [N-1:0]   mem [2**M];

  logic [M-1:0]   widx;
  logic [LB-1:0]  lane;
  logic           active;
  logic           bad;
  logic [N/8-1:0] strb;
  logic [N-1:0]   wdata;
  logic [N-1:0]   ld_data;

  assign widx   = adrs[AB-1:LB];
  assign lane   = adrs[LB-1:0];
  assign active = req && (state == READY);
  assign bad    = misaligned(size, 3'(lane), N == 64);
  assign strb   = (N/8)'(byte_mask(size, 3'(lane)));
  assign wdata  = data_w << {lane, 3'b000};

  dmem_load_align #(.N(N)) u_align (
    .word (mem[widx]),
    .size (size),
    .lane (lane),
    .uns  (uns),
    .data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RST ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && cnt == '1) state_nx = READY;
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // The array itself is never reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (active && WE && !bad) begin
        for (int b = 0; b < N / 8; b++) begin
          if (strb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rvalid   <= active && !WE;
      misalign <= active && bad;
      if (active && !WE) data_r <= bad ? '0 : ld_data;
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: a 32-bit, 16-word instance for most features
// and a 64-bit, 16-word instance for dword and wide extension.
module tb_dmem_sized;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req, WE, uns;
  logic [1:0]  size;
  logic [5:0]  adrs;
  logic [31:0] data_w, data_r;
  logic        rvalid, misalign, busy;

  logic        rst64, req64, we64, uns64;
  logic [1:0]  size64;
  logic [6:0]  adrs64;
  logic [63:0] data_w64, data_r64;
  logic        rvalid64, misalign64, busy64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_sized #(.N(32), .M(4), .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .WE(WE), .size(size), .uns(uns),
    .adrs(adrs), .data_w(data_w), .data_r(data_r), .rvalid(rvalid),
    .misalign(misalign), .busy(busy)
  );

  dmem_sized #(.N(64), .M(4), .CLEAR_ON_RST(1'b1)) dut64 (
    .clk(clk), .rst(rst64), .req(req64), .WE(we64), .size(size64), .uns(uns64),
    .adrs(adrs64), .data_w(data_w64), .data_r(data_r64), .rvalid(rvalid64),
    .misalign(misalign64), .busy(busy64)
  );

  // One request cycle; returns at edge+1 with outputs of that request visible.
  task automatic drive(input logic we, input logic [1:0] sz, input logic u,
                       input logic [5:0] a, input logic [31:0] d);
    req = 1'b1; WE = we; size = sz; uns = u; adrs = a; data_w = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drive64(input logic we, input logic [1:0] sz, input logic u,
                         input logic [6:0] a, input logic [63:0] d);
    req64 = 1'b1; we64 = we; size64 = sz; uns64 = u; adrs64 = a; data_w64 = d;
    @(posedge clk); #1;
    req64 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_r !== 32'h0 || rvalid !== 1'b0 || misalign !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got data_r=%h rvalid=%b misalign=%b busy=%b want 0/0/0/1",
               data_r, rvalid, misalign, busy);
    end
  endtask

  task automatic test_clear;
    int n = 0;
    int seen = 0;
    rst = 1'b0;
    req = 1'b1; WE = 1'b0; size = SZ_W; adrs = 6'd0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
      if (rvalid !== 1'b0) seen++;
    end
    req = 1'b0;
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL clear_len got busy_cycles=%0d want 16", n);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL busy_req_ignored got rvalid_count=%0d want 0", seen);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, SZ_W, 1'b0, 6'(i * 4), 32'h0);
      checks++;
      if (data_r !== 32'h0 || rvalid !== 1'b1) begin
        errors++;
        $display("FAIL clear_word%0d got data_r=%h rvalid=%b want 00000000/1", i, data_r, rvalid);
      end
    end
  endtask

  task automatic test_bytes;
    drive(1'b1, SZ_B, 1'b0, 6'd0, 32'h11);
    checks++;
    if (rvalid !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL store_no_rvalid got rvalid=%b misalign=%b want 0/0", rvalid, misalign);
    end
    drive(1'b1, SZ_B, 1'b0, 6'd1, 32'h22);
    drive(1'b1, SZ_B, 1'b0, 6'd2, 32'h33);
    drive(1'b1, SZ_B, 1'b0, 6'd3, 32'hF4);
    drive(1'b0, SZ_W, 1'b0, 6'd0, 32'h0);
    checks++;
    if (data_r !== 32'hF433_2211 || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL byte_word_load got %h rvalid=%b want f4332211/1", data_r, rvalid);
    end
    drive(1'b0, SZ_B, 1'b0, 6'd3, 32'h0);
    checks++;
    if (data_r !== 32'hFFFF_FFF4) begin
      errors++;
      $display("FAIL byte_signed got %h want fffffff4", data_r);
    end
    drive(1'b0, SZ_B, 1'b1, 6'd3, 32'h0);
    checks++;
    if (data_r !== 32'h0000_00F4) begin
      errors++;
      $display("FAIL byte_unsigned got %h want 000000f4", data_r);
    end
    drive(1'b0, SZ_B, 1'b0, 6'd1, 32'h0);
    checks++;
    if (data_r !== 32'h0000_0022) begin
      errors++;
      $display("FAIL byte_lane1 got %h want 00000022", data_r);
    end
  endtask

  task automatic test_half;
    drive(1'b1, SZ_H, 1'b0, 6'd6, 32'h0000_8001);
    drive(1'b0, SZ_H, 1'b0, 6'd6, 32'h0);
    checks++;
    if (data_r !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL half_signed got %h want ffff8001", data_r);
    end
    drive(1'b0, SZ_W, 1'b0, 6'd4, 32'h0);
    checks++;
    if (data_r !== 32'h8001_0000) begin
      errors++;
      $display("FAIL half_word_view got %h want 80010000", data_r);
    end
    // Idle cycle: data_r holds, rvalid drops.
    @(posedge clk); #1;
    checks++;
    if (data_r !== 32'h8001_0000 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL data_hold got %h rvalid=%b want 80010000/0", data_r, rvalid);
    end
  endtask

  task automatic test_misalign;
    drive(1'b1, SZ_W, 1'b0, 6'd2, 32'hAAAA_AAAA);
    checks++;
    if (misalign !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mis_store got misalign=%b rvalid=%b want 1/0", misalign, rvalid);
    end
    drive(1'b0, SZ_W, 1'b0, 6'd0, 32'h0);
    checks++;
    if (data_r !== 32'hF433_2211 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_no_write got %h misalign=%b want f4332211/0", data_r, misalign);
    end
    drive(1'b0, SZ_H, 1'b0, 6'd5, 32'h0);
    checks++;
    if (data_r !== 32'h0 || rvalid !== 1'b1 || misalign !== 1'b1) begin
      errors++;
      $display("FAIL mis_half_load got %h rvalid=%b misalign=%b want 0/1/1", data_r, rvalid, misalign);
    end
    drive(1'b0, SZ_D, 1'b0, 6'd0, 32'h0);
    checks++;
    if (data_r !== 32'h0 || rvalid !== 1'b1 || misalign !== 1'b1) begin
      errors++;
      $display("FAIL dword_on_32 got %h rvalid=%b misalign=%b want 0/1/1", data_r, rvalid, misalign);
    end
    @(posedge clk); #1;
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_pulse got misalign=%b want 0", misalign);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    drive(1'b1, SZ_W, 1'b0, 6'd8, 32'hDEAD_BEEF);
    drive(1'b0, SZ_W, 1'b0, 6'd8, 32'h0);
    checks++;
    if (data_r !== 32'hDEAD_BEEF || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL store_then_load got %h rvalid=%b want deadbeef/1", data_r, rvalid);
    end
    exp_q = '{32'hF433_2211, 32'h8001_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; WE = 1'b0; size = SZ_W; uns = 1'b0; adrs = 6'(i * 4);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      checks++;
      if (data_r !== exp || rvalid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_load%0d got %h rvalid=%b want %h/1", i, data_r, rvalid, exp);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    // Reset coinciding with a load suppresses its response.
    req = 1'b1; WE = 1'b0; size = SZ_W; adrs = 6'd0; rst = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || data_r !== 32'h0) begin
      errors++;
      $display("FAIL rst_cancels_load got rvalid=%b data_r=%h want 0/0", rvalid, data_r);
    end
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy got busy=%b want 1", busy);
    end
    rst = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL rst_mid_resweep got busy_cycles=%0d want 16", n);
    end
  endtask

  task automatic test_n64;
    int n = 0;
    rst64 = 1'b0;
    while (busy64 === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL n64_clear_len got busy_cycles=%0d want 16", n);
    end
    drive64(1'b1, SZ_D, 1'b0, 7'd8, 64'h0123_4567_89AB_CDEF);
    drive64(1'b0, SZ_D, 1'b0, 7'd8, 64'h0);
    checks++;
    if (data_r64 !== 64'h0123_4567_89AB_CDEF || rvalid64 !== 1'b1) begin
      errors++;
      $display("FAIL n64_dword got %h rvalid=%b want 0123456789abcdef/1", data_r64, rvalid64);
    end
    drive64(1'b0, SZ_W, 1'b0, 7'd8, 64'h0);
    checks++;
    if (data_r64 !== 64'hFFFF_FFFF_89AB_CDEF) begin
      errors++;
      $display("FAIL n64_word_signed got %h want ffffffff89abcdef", data_r64);
    end
    drive64(1'b0, SZ_W, 1'b0, 7'd12, 64'h0);
    checks++;
    if (data_r64 !== 64'h0000_0000_0123_4567) begin
      errors++;
      $display("FAIL n64_word_hi got %h want 0000000001234567", data_r64);
    end
    drive64(1'b0, SZ_D, 1'b0, 7'd4, 64'h0);
    checks++;
    if (misalign64 !== 1'b1 || rvalid64 !== 1'b1 || data_r64 !== 64'h0) begin
      errors++;
      $display("FAIL n64_dword_mis got misalign=%b rvalid=%b data=%h want 1/1/0",
               misalign64, rvalid64, data_r64);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; WE = 1'b0; size = SZ_B; uns = 1'b0; adrs = '0; data_w = '0;
    rst64 = 1'b1; req64 = 1'b0; we64 = 1'b0; size64 = SZ_B; uns64 = 1'b0;
    adrs64 = '0; data_w64 = '0;
    test_reset;
    test_clear;
    test_bytes;
    test_half;
    test_misalign;
    test_back_to_back;
    test_reset_mid;
    test_n64;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised single-port data memory for the RISC-V core's load/store stage; successor to the plain word memory.
- Adds byte/half/word/dword sizes with byte-lane strobes and sign/zero-extended loads.
- Adds a registered one-cycle read, misalignment detection and a full-array clear sequencer after reset.
- Sits between the execute stage's load/store unit and writeback.

Parameters:
- N, 32, data width in bits; legal values 32 or 64.
- M, 10, word-address bits; depth is 2**M words.
- CLEAR_ON_RST, 1, when 1 reset starts the array-clear sweep; when 0 reset only resets control and outputs.
- Localparam LB = log2(N/8): byte-offset bits. Localparam AB = M+LB: byte-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  access request, sampled at the rising edge
- WE  in  1  1 = store, 0 = load; qualified by req
- size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when N=64)
- uns  in  1  loads: 1 = zero-extend, 0 = sign-extend
- adrs  in  AB  byte address
- data_w  in  N  store data, right-aligned (low bits)
- data_r  out  N  load result, extended to N
- rvalid  out  1  one-cycle pulse; data_r is valid
- misalign  out  1  one-cycle pulse; the request was rejected
- busy  out  1  clear sweep in progress; req is ignored

Behaviour:
- States: CLEAR, READY.
- Reset, when rst=1 at an edge:
  - Outputs go to data_r=0, rvalid=0, misalign=0.
  - Clear counter goes to 0.
  - Next state is CLEAR if CLEAR_ON_RST=1, else READY.
  - Reset asserted mid-sweep restarts the counter at 0.
  - Reset asserted during a load cancels the pending rvalid.
- CLEAR:
  - busy=1.
  - Each cycle, word[counter] <= 0 and counter increments.
  - After writing word 2**M-1, go to READY. The sweep takes exactly 2**M cycles after reset is released.
  - req is ignored entirely: no write, no rvalid, no misalign.
- READY: busy=0.
- Address split:
  - Word index = adrs[AB-1:LB].
  - Lane = adrs[LB-1:0].
- Alignment:
  - half requires adrs[0]=0.
  - word requires adrs[1:0]=0.
  - dword requires adrs[2:0]=0.
  - size=11 with N=32 is illegal and is treated as misaligned.
- Store (req&WE, aligned):
  - At the edge, write only the addressed bytes.
  - Byte k of data_w goes to lane+k.
  - Other bytes of the word are unchanged.
  - No rvalid.
- Load (req&~WE, aligned):
  - Latency is 1. Sampled at edge k, data_r and rvalid=1 are presented in the cycle after edge k.
  - data_r = the selected bytes shifted to bit 0, then extended (sign from the MSB of the selected field unless uns=1).
  - data_r holds its value until the next load completes.
  - rvalid is high for one cycle only.
- Misaligned or illegal request:
  - No array write.
  - misalign=1 for one cycle after the edge.
  - For a load: rvalid=1 in the same cycle, with data_r=0.
- Store followed immediately by a load of the same word returns the new data (write-before-read order within the array).
- Back-to-back loads every cycle give one rvalid per cycle.
- No read data is ever combinational from adrs.

Decomposition:
- Shared package dmem_pkg holds:
  - Size encodings SZ_B, SZ_H, SZ_W, SZ_D.
  - State enum {CLEAR, READY}.
  - Function for the byte-strobe mask from size and lane.
- One sub-module, dmem_load_align: combinational lane extraction and sign/zero extension, parametrised by N. The top module registers its output.

Test Plan:
- Clear sweep, N=32, M=4: hold rst=1 for 2 cycles, then release. busy=1 for exactly 16 cycles, then 0. A word load from every address returns 0 with rvalid one cycle later. A req issued while busy produces no rvalid.
- Byte stores: store bytes 0x11, 0x22, 0x33, 0xF4 to adrs 0, 1, 2, 3.
  - Word load at adrs 0 -> data_r=0xF4332211.
  - Byte load at adrs 3 with uns=0 -> 0xFFFFFFF4; with uns=1 -> 0x000000F4.
- Half store/load: half store 0x8001 at adrs 6, then signed half load at adrs 6 -> 0xFFFF8001. Word load at adrs 4 -> upper half 0x8001, lower half unchanged.
- Misalign: word store at adrs 0x2 -> misalign pulse, and a word load from 0 shows memory unchanged. Half load at adrs 0x5 -> rvalid=1, misalign=1, data_r=0. size=11 with N=32 -> misalign.
- Pipelining: store 0xDEADBEEF at adrs 8, with a word load of adrs 8 on the next cycle -> 0xDEADBEEF. Four back-to-back loads -> four consecutive rvalid pulses with the matching data.
- Reset mid-sweep: assert rst at sweep cycle 7. busy stays high, and a fresh full 16-cycle sweep follows release. Repeat with N=64: dword store/load at adrs 8 round-trips 0x0123456789ABCDEF.
